// File: rtl/demux_pkg.sv
// Shared definitions for the demux/mux family: packet FSM encodings and a clog2 helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package demux_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    // Ceiling log2 usable in constant expressions; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/demux_out_reg.sv
// Holding register for the demux plus one-hot valid decode and zero-masked data fan-out.
// Latency: a beat loaded on edge N appears on out_valid/out_data in cycle N+1.
// Backpressure: contents are held until consume; a load in the same cycle replaces the beat.
module demux_out_reg #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [SEL_W-1:0]          load_sel,
    input  logic [WIDTH-1:0]          load_data,
    input  logic                      consume,
    output logic [CHANNELS-1:0]       out_valid,
    output logic [CHANNELS*WIDTH-1:0] out_data
);

    logic             valid_q;
    logic [SEL_W-1:0] sel_q;
    logic [WIDTH-1:0] data_q;

    // Load on accept, otherwise drop valid once the selected consumer takes the beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sel_q   <= '0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            sel_q   <= load_sel;
            data_q  <= load_data;
        end else if (consume) begin
            valid_q <= 1'b0;
        end
    end

    // Decode sel_q to one channel; unselected channels always read zero data.
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel_q == SEL_W'(i)) begin
                out_valid[i]              = valid_q;
                out_data[i*WIDTH +: WIDTH] = data_q;
            end
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-CHANNELS stream demux with optional packet-locked routing and drop counting.
// Latency: one cycle from accept to output; full throughput when the selected channel is ready.
// Backpressure: in_ready follows only the ready of the channel currently holding a beat.
module stream_demux
    import demux_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter bit PACKET_MODE = 1'b0,
    localparam int SEL_W      = (clog2(CHANNELS) < 1) ? 1 : clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_last,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [7:0]                drop_cnt,
    output logic                      drop_pulse
);

    // One extra bit so the channel count itself is representable for the range check.
    localparam logic [SEL_W:0] CH_LIM = CHANNELS[SEL_W:0];

    logic             state;
    logic [SEL_W-1:0] pkt_sel;
    logic [SEL_W-1:0] eff_sel;
    logic             in_range;
    logic             accept;
    logic             load;
    logic             drop;
    logic             consume;

    // out_valid is one-hot when a beat is held, so this is out_ready[sel_q] gated by valid_q.
    assign consume  = |(out_valid & out_ready);
    assign in_ready = !(|out_valid) || consume;
    assign accept   = in_valid && in_ready;

    // Mid-packet beats follow the select latched on the packet's first beat.
    assign eff_sel  = (PACKET_MODE && (state == ST_BUSY)) ? pkt_sel : in_sel;
    assign in_range = ({1'b0, eff_sel} < CH_LIM);
    assign load     = accept && in_range;
    assign drop     = accept && !in_range;

    // Packet FSM: latch the route on the first beat, release it after the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            pkt_sel <= '0;
        end else if (PACKET_MODE && accept) begin
            if (state == ST_IDLE) begin
                pkt_sel <= in_sel;
                if (!in_last) begin
                    state <= ST_BUSY;
                end
            end else if (in_last) begin
                state <= ST_IDLE;
            end
        end
    end

    // Saturating drop counter with a one-cycle pulse per dropped beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt   <= 8'd0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= drop;
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    demux_out_reg #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_sel  (eff_sel),
        .load_data (in_data),
        .consume   (consume),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_stream_demux.sv
// Directed-vector bench for stream_demux in three configurations sharing one clock and reset.
// Latency: beats are checked on the falling edge after the accepting rising edge.
// Backpressure: exercised by stalling one channel and by out-of-range drops.
module tb_stream_demux;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=8, CHANNELS=4, PACKET_MODE=0
    logic        a_in_valid, a_in_ready, a_in_last, a_drop_pulse;
    logic [7:0]  a_in_data, a_drop_cnt;
    logic [1:0]  a_in_sel;
    logic [3:0]  a_out_valid, a_out_ready;
    logic [31:0] a_out_data;

    // Instance B: WIDTH=8, CHANNELS=3, PACKET_MODE=0
    logic        b_in_valid, b_in_ready, b_in_last, b_drop_pulse;
    logic [7:0]  b_in_data, b_drop_cnt;
    logic [1:0]  b_in_sel;
    logic [2:0]  b_out_valid, b_out_ready;
    logic [23:0] b_out_data;

    // Instance C: WIDTH=8, CHANNELS=4, PACKET_MODE=1
    logic        c_in_valid, c_in_ready, c_in_last, c_drop_pulse;
    logic [7:0]  c_in_data, c_drop_cnt;
    logic [1:0]  c_in_sel;
    logic [3:0]  c_out_valid, c_out_ready;
    logic [31:0] c_out_data;

    stream_demux #(.WIDTH(8), .CHANNELS(4), .PACKET_MODE(1'b0)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_sel(a_in_sel), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .drop_cnt(a_drop_cnt), .drop_pulse(a_drop_pulse)
    );

    stream_demux #(.WIDTH(8), .CHANNELS(3), .PACKET_MODE(1'b0)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_sel(b_in_sel), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .drop_cnt(b_drop_cnt), .drop_pulse(b_drop_pulse)
    );

    stream_demux #(.WIDTH(8), .CHANNELS(4), .PACKET_MODE(1'b1)) u_dut_c (
        .clk(clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .in_sel(c_in_sel), .in_last(c_in_last),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .drop_cnt(c_drop_cnt), .drop_pulse(c_drop_pulse)
    );

    int n_chk;
    int n_pass;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Expected packed out_data: byte d placed in channel ch, all other lanes zero.
    function automatic logic [31:0] lane(input int ch, input logic [7:0] d);
        logic [31:0] v;
        v = {24'h0, d};
        return v << (8 * ch);
    endfunction

    // Packet-mode vectors: data, in_sel, in_last, expected channel
    logic [7:0] pk_dat [5];
    logic [1:0] pk_sel [5];
    logic       pk_lst [5];
    int         pk_ch  [5];

    initial begin
        logic [3:0] vld_seen;
        int         pulse_miss;
        int         ch;

        n_chk = 0;
        n_pass = 0;
        pk_dat = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0};
        pk_sel = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd3};
        pk_lst = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        pk_ch  = '{1, 1, 1, 1, 3};

        rst = 1'b1;
        a_in_valid = 0; a_in_data = 0; a_in_sel = 0; a_in_last = 0; a_out_ready = 4'hF;
        b_in_valid = 0; b_in_data = 0; b_in_sel = 0; b_in_last = 0; b_out_ready = 3'h7;
        c_in_valid = 0; c_in_data = 0; c_in_sel = 0; c_in_last = 0; c_out_ready = 4'hF;

        // Reset / idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_a_out_valid", 32'(a_out_valid), 32'h0);
        chk("rst_a_out_data", a_out_data, 32'h0);
        chk("rst_a_in_ready", 32'(a_in_ready), 32'h1);
        chk("rst_a_drop_cnt", 32'(a_drop_cnt), 32'h0);
        chk("rst_a_drop_pulse", 32'(a_drop_pulse), 32'h0);
        chk("rst_b_in_ready", 32'(b_in_ready), 32'h1);
        chk("rst_c_out_valid", 32'(c_out_valid), 32'h0);

        // Streaming sweep on A: one beat per cycle, sel 0..3 twice
        for (int k = 0; k < 8; k++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'h10 + 8'(k);
            a_in_sel   = 2'(k % 4);
            @(negedge clk);
            chk($sformatf("sweep%0d_vld", k), 32'(a_out_valid), 32'(1 << (k % 4)));
            chk($sformatf("sweep%0d_dat", k), a_out_data, lane(k % 4, 8'h10 + 8'(k)));
            chk($sformatf("sweep%0d_rdy", k), 32'(a_in_ready), 32'h1);
        end
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("sweep_drain_vld", 32'(a_out_valid), 32'h0);

        // Backpressure on A: ch2 stalled, 0xA5 to ch2 then 0x5A to ch1
        a_out_ready = 4'b1011;
        a_in_valid  = 1'b1;
        a_in_data   = 8'hA5;
        a_in_sel    = 2'd2;
        @(negedge clk);
        chk("bp_hold_vld", 32'(a_out_valid), 32'h4);
        chk("bp_hold_dat", a_out_data, lane(2, 8'hA5));
        a_in_data = 8'h5A;
        a_in_sel  = 2'd1;
        #1;
        chk("bp_in_ready_low", 32'(a_in_ready), 32'h0);
        @(negedge clk);
        chk("bp_still_vld", 32'(a_out_valid), 32'h4);
        chk("bp_still_dat", a_out_data, lane(2, 8'hA5));
        chk("bp_still_rdy", 32'(a_in_ready), 32'h0);
        // Other channels' ready going low must not matter while ch2 holds the beat
        a_out_ready = 4'b0100;
        #1;
        chk("bp_other_rdy", 32'(a_in_ready), 32'h1);
        a_out_ready = 4'hF;
        #1;
        chk("bp_release_rdy", 32'(a_in_ready), 32'h1);
        @(negedge clk);
        chk("bp_next_vld", 32'(a_out_valid), 32'h2);
        chk("bp_next_dat", a_out_data, lane(1, 8'h5A));
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drain_vld", 32'(a_out_valid), 32'h0);

        // Drop and saturate on B: in_sel=3 with CHANNELS=3, 260 beats
        vld_seen = '0;
        pulse_miss = 0;
        b_in_valid = 1'b1;
        b_in_sel   = 2'd3;
        for (int k = 0; k < 260; k++) begin
            b_in_data = 8'(k);
            @(negedge clk);
            vld_seen   = vld_seen | {1'b0, b_out_valid};
            pulse_miss = pulse_miss + ((b_drop_pulse == 1'b1) ? 0 : 1);
            if (k == 2) begin
                chk("drop_cnt_3", 32'(b_drop_cnt), 32'd3);
            end
        end
        chk("drop_no_valid", 32'(vld_seen), 32'h0);
        chk("drop_pulse_every", 32'(pulse_miss), 32'd0);
        chk("drop_cnt_sat", 32'(b_drop_cnt), 32'd255);
        chk("drop_rdy", 32'(b_in_ready), 32'h1);
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("drop_pulse_off", 32'(b_drop_pulse), 32'h0);
        chk("drop_cnt_hold", 32'(b_drop_cnt), 32'd255);
        // Highest in-range select still routes
        b_in_valid = 1'b1;
        b_in_sel   = 2'd2;
        b_in_data  = 8'h77;
        @(negedge clk);
        chk("b_ch2_vld", 32'(b_out_valid), 32'h4);
        chk("b_ch2_dat", 32'(b_out_data), lane(2, 8'h77));
        chk("b_ch2_nopulse", 32'(b_drop_pulse), 32'h0);
        b_in_valid = 1'b0;
        @(negedge clk);

        // Packet lock on C: 4-beat packet locked to ch1, then single beat to ch3
        for (int k = 0; k < 5; k++) begin
            c_in_valid = 1'b1;
            c_in_data  = pk_dat[k];
            c_in_sel   = pk_sel[k];
            c_in_last  = pk_lst[k];
            @(negedge clk);
            ch = pk_ch[k];
            chk($sformatf("pkt%0d_vld", k), 32'(c_out_valid), 32'(1 << ch));
            chk($sformatf("pkt%0d_dat", k), c_out_data, lane(ch, pk_dat[k]));
        end
        c_in_valid = 1'b0;
        c_in_last  = 1'b0;
        @(negedge clk);
        chk("pkt_drain_vld", 32'(c_out_valid), 32'h0);

        // Reset mid-packet on C: two beats of a ch1 packet, reset, then sel=2
        c_in_valid = 1'b1;
        c_in_data  = 8'hE0;
        c_in_sel   = 2'd1;
        @(negedge clk);
        c_in_data = 8'hE1;
        c_in_sel  = 2'd2;
        @(negedge clk);
        chk("mid_busy_vld", 32'(c_out_valid), 32'h2);
        chk("mid_busy_dat", c_out_data, lane(1, 8'hE1));
        c_in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(c_out_valid), 32'h0);
        chk("mid_rst_dat", c_out_data, 32'h0);
        chk("mid_rst_rdy", 32'(c_in_ready), 32'h1);
        chk("mid_rst_b_cnt", 32'(b_drop_cnt), 32'h0);
        c_in_valid = 1'b1;
        c_in_data  = 8'hE2;
        c_in_sel   = 2'd2;
        c_in_last  = 1'b1;
        @(negedge clk);
        chk("after_rst_vld", 32'(c_out_valid), 32'h4);
        chk("after_rst_dat", c_out_data, lane(2, 8'hE2));
        c_in_valid = 1'b0;
        c_in_last  = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
